result_output_arbiter: RTL and testbench
========================================

// Module: result_output_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing one 32-bit output channel among N result producers.
//  Grants one requester, captures its word, pulses init_bs and presents the word on out_data.
//  Completes a two-phase got_data handshake (rise, then fall), then re-arbitrates.
//  Sits between the processing cores and the external output port; counts delivered words.
// PARAMETERS
//  N_REQ  4   number of requesters (>=2)
//  DW     32  data word width
//  CNT_W  16  width of delivered-word counter (wraps)
// PORTS
//  clk        in   1           clock, rising edge
//  rst        in   1           reset, asynchronous, active-high
//  req_valid  in   N_REQ       per-requester "result ready"
//  req_data   in   N_REQ*DW    requester i data at [i*DW +: DW]
//  req_ack    out  N_REQ       one-hot, 1-cycle pulse: word of requester i captured
//  got_data   in   1           receiver handshake (high = taken, low = released)
//  out_data   out  DW          captured word, held stable until next capture
//  out_valid  out  1           word presented, awaiting got_data
//  out_empty  out  1           channel idle, no word held
//  init_bs    out  1           1-cycle start pulse for downstream serializer
//  grant_id   out  clog2(N_REQ) index of requester owning the current word
//  word_count out  CNT_W       words fully delivered since reset
// BEHAVIOUR
//  Reset: state IDLE; out_data=0, out_valid=0, out_empty=1, req_ack=0, init_bs=0,
//   grant_id=0, word_count=0, last-grant pointer=N_REQ-1 (requester 0 wins first).
//  FSM (registered state; registered outputs):
//   IDLE     out_empty=1. On edge with any req_valid: winner = first set bit searching
//            (ptr+1) mod N_REQ upward, wrapping; latch out_data, grant_id, ptr<=winner -> LOAD.
//            No request: stay.
//   LOAD     exactly 1 cycle: req_ack[grant_id]=1, init_bs=1 -> WAIT_GOT.
//   WAIT_GOT out_valid=1; got_data=1 -> WAIT_REL, else stay.
//   WAIT_REL out_valid=0, data held; got_data=0 -> IDLE and word_count+=1 (mod 2^CNT_W).
//            got_data still 1: stay (no timeout).
//  Latency: req sampled at edge k -> ack/init_bs during cycle k..k+1 -> out_valid from edge k+1.
//   Minimum 4 cycles per word (IDLE, LOAD, WAIT_GOT, WAIT_REL).
//  Requester rule: drop req_valid (or present next word) the cycle after req_ack;
//   a still-high req_valid on return to IDLE counts as a new request.
//  req_valid changing during LOAD/WAIT_*: ignored; only sampled in IDLE.
//  got_data in IDLE/LOAD: ignored. got_data already 1 on entering WAIT_GOT: advance next edge.
//  Requester owning ptr re-wins only if no other requester is valid (fairness).
//  Reset mid-operation: immediate return to reset values; in-flight word discarded, not counted.
//  req_ack, init_bs never high outside LOAD; out_valid and out_empty never high together.
// TESTING
//  1 Single: req_valid[2]=1, data 0xDEADBEEF -> ack=0100 1 cycle, init_bs 1 cycle,
//    out_valid=1, out_data=DEADBEEF, grant_id=2; got_data 1 for 2 cyc then 0 -> out_empty=1, count=1.
//  2 All four requesters valid after reset, data 0xA0..0xA3 -> served 0,1,2,3 in order, count=4.
//  3 Fairness: req 1 and 3 held high continuously -> grants alternate 1,3,1,3.
//  4 got_data held high 5 cycles -> FSM stays WAIT_REL, out_valid=0, out_data held, no re-grant.
//  5 Assert rst during WAIT_GOT -> outputs at reset values same cycle, count=0, next grant to req 0.
//  6 CNT_W=4: 16 complete transfers -> word_count wraps to 0; 17th -> 1.

Source files
------------

// File: rtl/result_output_arbiter_if.sv
// Handshake bundle between the result producers, the round-robin output arbiter
// and the external output receiver.
interface result_output_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned DW    = 32,
  parameter int unsigned CNT_W = 16
);
  localparam int unsigned GW = $clog2(N_REQ);

  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ-1:0]    req_ack;
  logic                got_data;
  logic [DW-1:0]       out_data;
  logic                out_valid;
  logic                out_empty;
  logic                init_bs;
  logic [GW-1:0]       grant_id;
  logic [CNT_W-1:0]    word_count;

  // arbiter side
  modport master (
    input  req_valid, req_data, got_data,
    output req_ack, out_data, out_valid, out_empty, init_bs, grant_id, word_count
  );

  // producers / receiver side
  modport slave (
    output req_valid, req_data, got_data,
    input  req_ack, out_data, out_valid, out_empty, init_bs, grant_id, word_count
  );
endinterface

// File: rtl/result_output_arbiter.sv
// Round-robin arbiter sharing one output word channel among N_REQ producers,
// with a two-phase got_data handshake and a delivered-word counter.
module result_output_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned DW    = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  result_output_arbiter_if.master  bus
);
  localparam int unsigned GW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_LOAD     = 2'd1,
    S_WAIT_GOT = 2'd2,
    S_WAIT_REL = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [GW-1:0]    ptr_q, ptr_d;
  logic [GW-1:0]    grant_q, grant_d;
  logic [DW-1:0]    data_q, data_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             init_q, init_d;
  logic             valid_q, valid_d;
  logic             empty_q, empty_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [GW-1:0]    winner;
  logic             any_req;

  // First valid requester after the last grant, wrapping around
  always_comb begin : rr_search
    int unsigned idx;
    idx     = 0;
    winner  = ptr_q;
    any_req = 1'b0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      idx = 32'(ptr_q) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!any_req && bus.req_valid[GW'(idx)]) begin
        any_req = 1'b1;
        winner  = GW'(idx);
      end
    end
  end

  // Next state and next registered outputs
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    data_d  = data_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d = S_LOAD;
          ptr_d   = winner;
          grant_d = winner;
          data_d  = DW'(bus.req_data >> (DW * 32'(winner)));
        end
      end
      S_LOAD:     state_d = S_WAIT_GOT;
      S_WAIT_GOT: if (bus.got_data) state_d = S_WAIT_REL;
      S_WAIT_REL: begin
        if (!bus.got_data) begin
          state_d = S_IDLE;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default:    state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they line up with it after the edge
    ack_d   = (state_d == S_LOAD) ? (N_REQ'(1) << grant_d) : '0;
    init_d  = (state_d == S_LOAD);
    valid_d = (state_d == S_WAIT_GOT);
    empty_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= GW'(N_REQ - 1);
      grant_q <= '0;
      data_q  <= '0;
      ack_q   <= '0;
      init_q  <= 1'b0;
      valid_q <= 1'b0;
      empty_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      init_q  <= init_d;
      valid_q <= valid_d;
      empty_q <= empty_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.req_ack    = ack_q;
  assign bus.init_bs    = init_q;
  assign bus.out_valid  = valid_q;
  assign bus.out_empty  = empty_q;
  assign bus.out_data   = data_q;
  assign bus.grant_id   = grant_q;
  assign bus.word_count = cnt_q;

endmodule

// File: tb/tb_result_output_arbiter.sv
// Self-checking bench for result_output_arbiter: directed vector table, hand-written
// corner sequences and randomized transfers against a transaction-level model.
module tb_result_output_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  result_output_arbiter_if #(.N_REQ(N), .DW(DW), .CNT_W(16)) bus ();
  result_output_arbiter_if #(.N_REQ(N), .DW(DW), .CNT_W(4))  bus4 ();

  // Narrow-counter instance sees identical stimulus
  assign bus4.req_valid = bus.req_valid;
  assign bus4.req_data  = bus.req_data;
  assign bus4.got_data  = bus.got_data;

  result_output_arbiter #(.N_REQ(N), .DW(DW), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  result_output_arbiter #(.N_REQ(N), .DW(DW), .CNT_W(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  int n_cmp = 0;
  int n_err = 0;
  int m_ptr;
  int m_count;

  typedef struct {
    logic [N-1:0]    mask;
    logic [N*DW-1:0] data;
    int              exp_g;
    int              wait_c;
    int              hold;
    bit              early;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Round-robin rule: rotate the request mask so the slot after ptr sits at bit 0
  function automatic int rr_pick(input logic [N-1:0] mask, input int ptr);
    logic [2*N-1:0] dbl;
    dbl = {mask, mask} >> (ptr + 1);
    for (int p = 0; p < N; p++)
      if (dbl[p]) return (ptr + 1 + p) % N;
    return -1;
  endfunction

  task automatic do_reset();
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.got_data  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_ptr   = N - 1;
    m_count = 0;
  endtask

  task automatic chk_count(input string tag);
    chk({tag, " word_count"},  64'(bus.word_count),  64'(m_count % 65536));
    chk({tag, " word_count4"}, 64'(bus4.word_count), 64'(m_count % 16));
  endtask

  // One complete word; entered and left just after a rising edge with the DUT idle
  task automatic xfer(input logic [N-1:0] mask, input logic [N*DW-1:0] data, input int exp_g,
                      input int wait_c, input int hold, input bit early);
    logic [DW-1:0] word;
    word          = DW'(data >> (exp_g * DW));
    bus.req_valid = mask;
    bus.req_data  = data;
    bus.got_data  = 1'($urandom);
    @(negedge clk);
    chk("idle out_empty", 64'(bus.out_empty), 64'(1));
    chk("idle out_valid", 64'(bus.out_valid), 64'(0));
    chk("idle req_ack",   64'(bus.req_ack),   64'(0));
    step();
    bus.req_valid = N'($urandom);
    bus.got_data  = early;
    @(negedge clk);
    chk("load req_ack",   64'(bus.req_ack),   64'(1) << exp_g);
    chk("load init_bs",   64'(bus.init_bs),   64'(1));
    chk("load grant_id",  64'(bus.grant_id),  64'(exp_g));
    chk("load out_data",  64'(bus.out_data),  64'(word));
    chk("load out_valid", 64'(bus.out_valid), 64'(0));
    chk("load out_empty", 64'(bus.out_empty), 64'(0));
    step();
    if (!early) begin
      for (int i = 0; i < wait_c; i++) begin
        @(negedge clk);
        chk("wait out_valid", 64'(bus.out_valid), 64'(1));
        chk("wait init_bs",   64'(bus.init_bs),   64'(0));
        bus.req_valid = N'($urandom);
        step();
      end
    end
    @(negedge clk);
    chk("got out_valid", 64'(bus.out_valid), 64'(1));
    chk("got out_empty", 64'(bus.out_empty), 64'(0));
    chk("got req_ack",   64'(bus.req_ack),   64'(0));
    chk("got out_data",  64'(bus.out_data),  64'(word));
    bus.got_data = 1'b1;
    step();
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      chk("rel out_valid", 64'(bus.out_valid), 64'(0));
      chk("rel out_empty", 64'(bus.out_empty), 64'(0));
      chk("rel req_ack",   64'(bus.req_ack),   64'(0));
      chk("rel out_data",  64'(bus.out_data),  64'(word));
      bus.req_valid = N'($urandom);
      step();
    end
    @(negedge clk);
    chk("rel last out_valid", 64'(bus.out_valid), 64'(0));
    chk("rel last grant_id",  64'(bus.grant_id),  64'(exp_g));
    bus.got_data  = 1'b0;
    bus.req_valid = '0;
    step();
    m_count++;
    m_ptr = exp_g;
    @(negedge clk);
    chk("done out_empty", 64'(bus.out_empty), 64'(1));
    chk("done out_valid", 64'(bus.out_valid), 64'(0));
    chk("done out_data",  64'(bus.out_data),  64'(word));
    chk_count("done");
    step();
  endtask

  initial begin
    logic [N-1:0]    rmask;
    logic [N*DW-1:0] rdata;

    tbl[0]  = '{4'b1111, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 0, 0, 1, 1'b0};
    tbl[1]  = '{4'b1110, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1, 1, 1, 1'b0};
    tbl[2]  = '{4'b1100, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 2, 0, 2, 1'b1};
    tbl[3]  = '{4'b1000, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 3, 2, 1, 1'b0};
    tbl[4]  = '{4'b1010, {32'h3333_0003, 32'h0, 32'h1111_0001, 32'h0}, 1, 0, 1, 1'b0};
    tbl[5]  = '{4'b1010, {32'h3333_0013, 32'h0, 32'h1111_0011, 32'h0}, 3, 0, 1, 1'b0};
    tbl[6]  = '{4'b1010, {32'h3333_0023, 32'h0, 32'h1111_0021, 32'h0}, 1, 1, 2, 1'b1};
    tbl[7]  = '{4'b1010, {32'h3333_0033, 32'h0, 32'h1111_0031, 32'h0}, 3, 3, 1, 1'b0};
    tbl[8]  = '{4'b0100, {32'h0, 32'hCAFE_F00D, 32'h0, 32'h0}, 2, 0, 1, 1'b0};
    tbl[9]  = '{4'b0001, {32'h0, 32'h0, 32'h0, 32'h1234_5678}, 0, 0, 1, 1'b0};
    tbl[10] = '{4'b0001, {32'h0, 32'h0, 32'h0, 32'h8765_4321}, 0, 1, 1, 1'b0};

    // Reset values
    do_reset();
    @(negedge clk);
    chk("rst out_empty", 64'(bus.out_empty), 64'(1));
    chk("rst out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst out_data",  64'(bus.out_data),  64'(0));
    chk("rst req_ack",   64'(bus.req_ack),   64'(0));
    chk("rst init_bs",   64'(bus.init_bs),   64'(0));
    chk("rst grant_id",  64'(bus.grant_id),  64'(0));
    chk_count("rst");
    step();
    repeat (3) begin
      @(negedge clk);
      chk("noreq out_empty", 64'(bus.out_empty), 64'(1));
      chk("noreq init_bs",   64'(bus.init_bs),   64'(0));
      step();
    end

    // Single request from requester 2, got_data held two cycles
    xfer(4'b0100, {32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0}, 2, 0, 2, 1'b0);

    // Directed table: ordering after reset, fairness, lone re-win
    do_reset();
    foreach (tbl[i]) xfer(tbl[i].mask, tbl[i].data, tbl[i].exp_g, tbl[i].wait_c, tbl[i].hold, tbl[i].early);

    // got_data stuck high for five cycles in the release phase
    xfer(4'b1111, {32'h44, 32'h33, 32'h22, 32'h11}, 1, 0, 5, 1'b0);

    // Reset asserted while a word awaits got_data
    bus.req_valid = 4'b0010;
    bus.req_data  = {32'h0, 32'h0, 32'h5A5A_A5A5, 32'h0};
    bus.got_data  = 1'b0;
    step();
    bus.req_valid = '0;
    step();
    @(negedge clk);
    chk("prerst out_valid", 64'(bus.out_valid), 64'(1));
    #1 rst = 1'b1;
    #1;
    chk("midrst out_valid", 64'(bus.out_valid),  64'(0));
    chk("midrst out_empty", 64'(bus.out_empty),  64'(1));
    chk("midrst out_data",  64'(bus.out_data),   64'(0));
    chk("midrst grant_id",  64'(bus.grant_id),   64'(0));
    chk("midrst count",     64'(bus.word_count), 64'(0));
    chk("midrst req_ack",   64'(bus.req_ack),    64'(0));
    step();
    rst     = 1'b0;
    m_ptr   = N - 1;
    m_count = 0;
    xfer(4'b1111, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 0, 0, 1, 1'b0);

    // Randomized transfers; more than 16 so the narrow counter wraps
    for (int it = 0; it < 40; it++) begin
      rmask = N'($urandom_range(1, (1 << N) - 1));
      rdata = {$urandom, $urandom, $urandom, $urandom};
      xfer(rmask, rdata, rr_pick(rmask, m_ptr), $urandom_range(0, 3), $urandom_range(1, 3),
           1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
